// File: rtl/ro_freq_counter_if.sv
// rtl/ro_freq_counter_if.sv - RO inputs, enable and window-latched count outputs
interface ro_freq_counter_if #(
  parameter int CNT_W = 32
);
  logic             enable;
  logic             INV_RO;
  logic             NAND_RO;
  logic             NOR_RO;
  logic             DIV_RO;
  logic [CNT_W-1:0] INV_COUNT;
  logic [CNT_W-1:0] NAND_COUNT;
  logic [CNT_W-1:0] NOR_COUNT;
  logic [CNT_W-1:0] DividerOutput_COUNT;
  logic             count_valid;
  logic [3:0]       ovf;

  modport master (
    output enable, INV_RO, NAND_RO, NOR_RO, DIV_RO,
    input  INV_COUNT, NAND_COUNT, NOR_COUNT, DividerOutput_COUNT, count_valid, ovf
  );

  modport slave (
    input  enable, INV_RO, NAND_RO, NOR_RO, DIV_RO,
    output INV_COUNT, NAND_COUNT, NOR_COUNT, DividerOutput_COUNT, count_valid, ovf
  );
endinterface

// File: rtl/ro_freq_counter.sv
// rtl/ro_freq_counter.sv - counts RO rising edges over a fixed data_clk gate window
module ro_freq_counter #(
  parameter int GATE_CYCLES = 1000000,
  parameter int CNT_W       = 32,
  parameter int SYNC_STAGES = 2
) (
  input logic              data_clk,
  input logic              reset,
  ro_freq_counter_if.slave bus
);

  localparam int                GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_COUNT = 2'd1,
    S_LATCH = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [GATE_W-1:0]      r_gate;
  logic [3:0]             w_ro;
  logic [SYNC_STAGES-1:0] r_sync [4];
  logic [3:0]             r_prev;
  logic [3:0]             w_rise;
  logic [CNT_W-1:0]       r_run [4];
  logic [CNT_W-1:0]       w_run_nxt [4];
  logic [3:0]             r_run_ovf;
  logic [3:0]             w_run_ovf_nxt;
  logic [CNT_W-1:0]       r_out [4];
  logic [3:0]             r_ovf;
  logic                   r_valid;

  // Channel order {DIV, NOR, NAND, INV} matches the ovf bit order.
  assign w_ro = {bus.DIV_RO, bus.NOR_RO, bus.NAND_RO, bus.INV_RO};

  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 4; ch++) begin
        r_sync[ch] <= '0;
      end
      r_prev <= '0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        r_sync[ch] <= {r_sync[ch][SYNC_STAGES-2:0], w_ro[ch]};
        r_prev[ch] <= r_sync[ch][SYNC_STAGES-1];
      end
    end
  end

  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      w_rise[ch] = r_sync[ch][SYNC_STAGES-1] & ~r_prev[ch];
    end
  end

  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_gate  <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_COUNT) && (w_state_nxt == S_COUNT)) begin
        r_gate <= r_gate + GATE_W'(1);
      end else begin
        r_gate <= '0;
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.enable) begin
          w_state_nxt = S_COUNT;
        end
      end
      S_COUNT: begin
        if (!bus.enable) begin
          w_state_nxt = S_IDLE;
        end else if (r_gate == GATE_LAST) begin
          w_state_nxt = S_LATCH;
        end
      end
      S_LATCH: begin
        w_state_nxt = bus.enable ? S_COUNT : S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // An edge seen during LATCH seeds the next window so nothing is dropped at the boundary.
  always_comb begin
    for (int ch = 0; ch < 4; ch++) begin
      w_run_nxt[ch]     = r_run[ch];
      w_run_ovf_nxt[ch] = r_run_ovf[ch];
      unique case (r_state)
        S_COUNT: begin
          if (!bus.enable) begin
            w_run_nxt[ch]     = '0;
            w_run_ovf_nxt[ch] = 1'b0;
          end else if (w_rise[ch]) begin
            if (r_run[ch] == CNT_MAX) begin
              w_run_ovf_nxt[ch] = 1'b1;
            end else begin
              w_run_nxt[ch] = r_run[ch] + CNT_W'(1);
            end
          end
        end
        S_LATCH: begin
          w_run_nxt[ch]     = {{(CNT_W-1){1'b0}}, w_rise[ch]};
          w_run_ovf_nxt[ch] = 1'b0;
        end
        default: begin
          w_run_nxt[ch]     = '0;
          w_run_ovf_nxt[ch] = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 4; ch++) begin
        r_run[ch] <= '0;
      end
      r_run_ovf <= '0;
    end else begin
      for (int ch = 0; ch < 4; ch++) begin
        r_run[ch] <= w_run_nxt[ch];
      end
      r_run_ovf <= w_run_ovf_nxt;
    end
  end

  always_ff @(posedge data_clk or negedge reset) begin
    if (!reset) begin
      for (int ch = 0; ch < 4; ch++) begin
        r_out[ch] <= '0;
      end
      r_ovf   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (r_state == S_LATCH) begin
        for (int ch = 0; ch < 4; ch++) begin
          r_out[ch] <= r_run[ch];
        end
        r_ovf   <= r_run_ovf;
        r_valid <= 1'b1;
      end
    end
  end

  assign bus.INV_COUNT           = r_out[0];
  assign bus.NAND_COUNT          = r_out[1];
  assign bus.NOR_COUNT           = r_out[2];
  assign bus.DividerOutput_COUNT = r_out[3];
  assign bus.ovf                 = r_ovf;
  assign bus.count_valid         = r_valid;

endmodule

// File: tb/tb_ro_freq_counter.sv
// tb/tb_ro_freq_counter.sv - bench for ro_freq_counter (32-bit and 4-bit instances)
module tb_ro_freq_counter;

  localparam int GATE = 100;
  localparam int WIN  = GATE + 1;

  typedef struct packed {
    int               L;
    logic [3:0][31:0] cnt;
    logic [3:0]       ovf;
  } vrec_t;

  typedef struct packed {
    logic [3:0][7:0]  hp;
    logic             has_exp;
    logic [3:0][15:0] ex;
  } vec_t;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       en    = 1'b0;
  logic [3:0] ro    = 4'b0;
  int         cyc   = 0;
  int         hp [4];
  int         ph [4];
  int         pulse_p [4];
  int         rq [4][$];
  vrec_t      vq [$];
  vrec_t      vq4 [$];
  int         n_cmp = 0;
  int         n_bad = 0;

  ro_freq_counter_if #(.CNT_W(32)) bus ();
  ro_freq_counter_if #(.CNT_W(4))  bus4 ();

  assign bus.enable   = en;
  assign bus.INV_RO   = ro[0];
  assign bus.NAND_RO  = ro[1];
  assign bus.NOR_RO   = ro[2];
  assign bus.DIV_RO   = ro[3];
  assign bus4.enable  = en;
  assign bus4.INV_RO  = ro[0];
  assign bus4.NAND_RO = ro[1];
  assign bus4.NOR_RO  = ro[2];
  assign bus4.DIV_RO  = ro[3];

  ro_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(32), .SYNC_STAGES(2)) dut (
    .data_clk (clk),
    .reset    (rst_n),
    .bus      (bus.slave)
  );

  ro_freq_counter #(.GATE_CYCLES(GATE), .CNT_W(4), .SYNC_STAGES(2)) dut4 (
    .data_clk (clk),
    .reset    (rst_n),
    .bus      (bus4.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // RO waveform generator: free-running square waves or single pulses; logs each rising edge
  // with the index of the data_clk edge that first samples it.
  initial begin
    for (int c = 0; c < 4; c++) begin
      hp[c] = 0;
      ph[c] = 0;
      pulse_p[c] = 0;
    end
  end

  always @(negedge clk) begin
    for (int c = 0; c < 4; c++) begin
      if (hp[c] != 0) begin
        ph[c] = ph[c] + 1;
        if (ph[c] >= hp[c]) begin
          ph[c] = 0;
          ro[c] = ~ro[c];
          if (ro[c]) rq[c].push_back(cyc + 1);
        end
      end else begin
        ph[c] = 0;
        if (pulse_p[c] == 0) begin
          ro[c] = 1'b0;
        end else if (cyc + 1 == pulse_p[c]) begin
          ro[c] = 1'b1;
          rq[c].push_back(cyc + 1);
        end else if (cyc + 1 == pulse_p[c] + 3) begin
          ro[c] = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin : mon
    vrec_t r;
    if (bus.count_valid === 1'b1) begin
      r.L   = cyc;
      r.cnt = {bus.DividerOutput_COUNT, bus.NOR_COUNT, bus.NAND_COUNT, bus.INV_COUNT};
      r.ovf = bus.ovf;
      vq.push_back(r);
    end
    if (bus4.count_valid === 1'b1) begin
      r.L   = cyc;
      r.cnt = {28'd0, bus4.DividerOutput_COUNT, 28'd0, bus4.NOR_COUNT,
               28'd0, bus4.NAND_COUNT, 28'd0, bus4.INV_COUNT};
      r.ovf = bus4.ovf;
      vq4.push_back(r);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic chk_tol(input string nm, input int act, input int exp, input int tol);
    n_cmp++;
    if (act < exp - tol || act > exp + tol) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (+/-%0d)", nm, act, exp, tol);
    end
  endtask

  task automatic get_valid(input bit four, input string nm, output vrec_t r);
    int t = 0;
    while ((four ? vq4.size() : vq.size()) == 0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    if ((four ? vq4.size() : vq.size()) == 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: no count_valid within 400 cycles", nm);
      r = '0;
    end else begin
      r = four ? vq4.pop_front() : vq.pop_front();
    end
  endtask

  function automatic int edges_in(input int c, input int lo, input int hi);
    int n = 0;
    foreach (rq[c][k]) if (rq[c][k] >= lo && rq[c][k] <= hi) n++;
    return n;
  endfunction

  // A window latched at edge L holds the edges sampled in the WIN edges ending two before L.
  task automatic chk_model(input string nm, input vrec_t w);
    for (int c = 0; c < 4; c++)
      chk_tol($sformatf("%s_model_ch%0d", nm, c), int'(w.cnt[c]),
              edges_in(c, w.L - WIN - 2, w.L - 3), 1);
  endtask

  task automatic go_idle();
    @(negedge clk);
    en = 1'b0;
    for (int c = 0; c < 4; c++) begin
      hp[c] = 0;
      pulse_p[c] = 0;
    end
    repeat (10) @(negedge clk);
    vq.delete();
    vq4.delete();
  endtask

  function automatic vec_t mk(input int h0, h1, h2, h3, input bit he, input int e0, e1, e2, e3);
    vec_t v;
    v.hp      = {8'(h3), 8'(h2), 8'(h1), 8'(h0)};
    v.has_exp = he;
    v.ex      = {16'(e3), 16'(e2), 16'(e1), 16'(e0)};
    return v;
  endfunction

  vec_t  vt [7];
  vrec_t w1, w2, w3, prev;
  int    n0, sum;

  initial begin
    vt[0] = mk(5, 2, 10, 25, 1'b1, 10, 25, 5, 2);
    vt[1] = mk(2, 3, 4, 6, 1'b1, 25, 16, 12, 8);
    vt[2] = mk(0, 0, 0, 0, 1'b1, 0, 0, 0, 0);
    vt[3] = mk(7, 0, 2, 3, 1'b1, 7, 0, 25, 16);
    for (int i = 4; i < 7; i++)
      vt[i] = mk($urandom_range(2, 15), $urandom_range(2, 15), $urandom_range(2, 15),
                 $urandom_range(0, 15) < 3 ? 0 : $urandom_range(2, 15), 1'b0, 0, 0, 0, 0);

    repeat (3) @(negedge clk);
    chk("reset_counts", {bus.DividerOutput_COUNT, bus.NOR_COUNT, bus.NAND_COUNT, bus.INV_COUNT}, '0);
    chk("reset_valid_ovf", {bus.count_valid, bus.ovf}, '0);
    chk("reset_dut4", {bus4.DividerOutput_COUNT, bus4.NOR_COUNT, bus4.NAND_COUNT, bus4.INV_COUNT,
                       bus4.count_valid, bus4.ovf}, '0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_no_valid", 128'(vq.size()), 128'd0);

    // Back-to-back windows per vector: latency, spacing, expected counts and edge conservation.
    for (int i = 0; i < 7; i++) begin
      go_idle();
      n0 = cyc;
      en = 1'b1;
      for (int c = 0; c < 4; c++) hp[c] = int'(vt[i].hp[c]);
      get_valid(1'b0, $sformatf("v%0d_w1", i), w1);
      chk($sformatf("v%0d_first_latency", i), 128'(w1.L - n0), 128'(1 + WIN));
      chk($sformatf("v%0d_ovf", i), 128'(w1.ovf), 128'd0);
      if (vt[i].has_exp)
        for (int c = 0; c < 4; c++)
          chk_tol($sformatf("v%0d_table_ch%0d", i, c), int'(w1.cnt[c]), int'(vt[i].ex[c]), 1);
      chk_model($sformatf("v%0d_w1", i), w1);
      get_valid(1'b0, $sformatf("v%0d_w2", i), w2);
      chk($sformatf("v%0d_spacing12", i), 128'(w2.L - w1.L), 128'(WIN));
      chk_model($sformatf("v%0d_w2", i), w2);
      repeat (60) @(negedge clk);
      for (int c = 0; c < 4; c++) hp[c] = 0;
      get_valid(1'b0, $sformatf("v%0d_w3", i), w3);
      chk($sformatf("v%0d_spacing23", i), 128'(w3.L - w2.L), 128'(WIN));
      chk_model($sformatf("v%0d_w3", i), w3);
      for (int c = 0; c < 4; c++) begin
        sum = int'(w1.cnt[c]) + int'(w2.cnt[c]) + int'(w3.cnt[c]);
        chk($sformatf("v%0d_conserve_ch%0d", i, c), 128'(sum), 128'(edges_in(c, n0, cyc + 10)));
      end
      prev = w3;
    end

    // Abort at gate=50: no update, outputs held; re-enable gives a full window.
    go_idle();
    n0 = cyc;
    en = 1'b1;
    hp[0] = 5; hp[1] = 2; hp[2] = 10; hp[3] = 25;
    while (cyc < n0 + 51) @(negedge clk);
    en = 1'b0;
    repeat (150) @(negedge clk);
    chk("abort_no_valid", 128'(vq.size()), 128'd0);
    chk("abort_hold_counts", {bus.DividerOutput_COUNT, bus.NOR_COUNT, bus.NAND_COUNT, bus.INV_COUNT},
        prev.cnt);
    chk("abort_hold_ovf", 128'(bus.ovf), 128'(prev.ovf));
    n0 = cyc;
    en = 1'b1;
    get_valid(1'b0, "reenable", w1);
    chk("reenable_latency", 128'(w1.L - n0), 128'(1 + WIN));
    chk_model("reenable", w1);

    // 4-bit instance: saturation with sticky ovf, then a quiet window clears both.
    go_idle();
    n0 = cyc;
    en = 1'b1;
    hp[0] = 2;
    while (cyc < n0 + 90) @(negedge clk);
    hp[0] = 0;
    get_valid(1'b1, "sat_w1", w1);
    chk("sat_inv_count", 128'(w1.cnt[0]), 128'd15);
    chk("sat_ovf", 128'(w1.ovf), 128'b0001);
    get_valid(1'b1, "sat_w2", w2);
    chk("sat_next_inv_count", 128'(w2.cnt[0]), 128'd0);
    chk("sat_next_ovf", 128'(w2.ovf), 128'd0);

    // Single INV pulse swept across the window boundary: counted exactly once.
    go_idle();
    en = 1'b1;
    get_valid(1'b0, "sweep_start", w1);
    for (int off = -4; off <= 3; off++) begin
      pulse_p[0] = w1.L + WIN - 2 + off;
      get_valid(1'b0, $sformatf("sweep%0d_a", off), w2);
      get_valid(1'b0, $sformatf("sweep%0d_b", off), w3);
      chk($sformatf("sweep%0d_once", off), 128'(int'(w2.cnt[0]) + int'(w3.cnt[0])), 128'd1);
      pulse_p[0] = 0;
      w1 = w3;
    end

    // Asynchronous reset mid-COUNT clears outputs immediately; IDLE until enable.
    go_idle();
    en = 1'b1;
    hp[0] = 5; hp[1] = 2; hp[2] = 10; hp[3] = 25;
    get_valid(1'b0, "prereset", w1);
    repeat (30) @(negedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    en = 1'b0;
    #1;
    chk("async_reset_counts", {bus.DividerOutput_COUNT, bus.NOR_COUNT, bus.NAND_COUNT, bus.INV_COUNT}, '0);
    chk("async_reset_valid_ovf", {bus.count_valid, bus.ovf}, '0);
    chk("async_reset_dut4", {bus4.DividerOutput_COUNT, bus4.NOR_COUNT, bus4.NAND_COUNT, bus4.INV_COUNT,
                             bus4.ovf}, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    vq.delete();
    repeat (150) @(negedge clk);
    chk("post_reset_idle", 128'(vq.size()), 128'd0);
    n0 = cyc;
    en = 1'b1;
    get_valid(1'b0, "post_reset", w1);
    chk("post_reset_latency", 128'(w1.L - n0), 128'(1 + WIN));
    chk_model("post_reset", w1);

    en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
